// File: rtl/mfp_ram_stream_pkg.sv
// Shared constants and pointer arithmetic for the RAM read streamer.
// Used by mfp_ram_read_streamer and mfp_stream_out_buf.
package mfp_ram_stream_pkg;

  localparam int OUT_BUF_DEPTH = 2;
  localparam int OUT_CNT_W     = $clog2(OUT_BUF_DEPTH + 1);

  // Wrapping subtraction a - b, reduced modulo 2**ptr_w (ptr_w <= 31).
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/mfp_stream_out_buf.sv
// Two-entry register FIFO that holds RAM return words in front of the stream.
// Entry 0 is always the head; a captured word lands right behind the live entries.
module mfp_stream_out_buf
  import mfp_ram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [OUT_CNT_W-1:0]  o_cnt,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [OUT_CNT_W-1:0]  r_cnt;
  logic [OUT_CNT_W-1:0]  w_tgt;
  logic [DATA_WIDTH-1:0] r_entry [OUT_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] w_next  [OUT_BUF_DEPTH];

  // Slot the pushed word goes to once this cycle's pop has shifted the queue.
  assign w_tgt = r_cnt - {{(OUT_CNT_W-1){1'b0}}, i_pop};

  genvar gi;
  generate
    for (gi = 0; gi < OUT_BUF_DEPTH; gi++) begin : g_ent
      logic [DATA_WIDTH-1:0] w_shift;
      if (gi == OUT_BUF_DEPTH - 1) begin : g_last
        assign w_shift = r_entry[gi];
      end else begin : g_mid
        assign w_shift = r_entry[gi+1];
      end
      assign w_next[gi] = (i_push && (w_tgt == OUT_CNT_W'(gi))) ? i_push_data :
                          i_pop                                 ? w_shift     :
                                                                  r_entry[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      for (int i = 0; i < OUT_BUF_DEPTH; i++) r_entry[i] <= '0;
    end else begin
      if (i_push && !i_pop)      r_cnt <= r_cnt + 1'b1;
      else if (i_pop && !i_push) r_cnt <= r_cnt - 1'b1;
      for (int i = 0; i < OUT_BUF_DEPTH; i++) r_entry[i] <= w_next[i];
    end
  end

  assign o_cnt  = r_cnt;
  assign o_head = r_entry[0];

endmodule

// File: rtl/mfp_ram_read_streamer.sv
// Read-side engine of a block-RAM FIFO: issues RAM reads against the writer pointer
// and streams words out as valid/ready. Optional MFP_RAM_STREAMER_LEVEL_EN adds a level port.
module mfp_ram_read_streamer
  import mfp_ram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef MFP_RAM_STREAMER_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  logic [ADDR_WIDTH:0]  r_rd_ptr;
  logic                 r_pend;
  logic [OUT_CNT_W-1:0] w_buf_cnt;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_issue;
  logic [2:0]           w_credit;
  logic [2:0]           w_limit;

  // Full-width compare: equal addresses with differing wrap bits means full, not empty.
  assign w_empty  = (wr_ptr == r_rd_ptr);
  assign w_pop    = out_valid & out_ready;
  // Words already committed (buffered + in flight) must leave room for the new read.
  assign w_credit = 3'(w_buf_cnt) + {2'b0, r_pend};
  assign w_limit  = 3'(OUT_BUF_DEPTH) + {2'b0, w_pop};
  assign w_issue  = !rst && !w_empty && (w_credit < w_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_pend <= w_issue;
    end
  end

  mfp_stream_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_pend),
    .i_push_data (read_data),
    .i_pop       (w_pop),
    .o_cnt       (w_buf_cnt),
    .o_head      (out_data)
  );

  assign out_valid   = (w_buf_cnt != '0);
  assign rd_ptr      = r_rd_ptr;
  assign read_addr   = r_rd_ptr[ADDR_WIDTH-1:0];
  assign read_enable = w_issue;

`ifdef MFP_RAM_STREAMER_LEVEL_EN
  logic [ADDR_WIDTH:0] r_level;
  logic [31:0]         w_diff;

  assign w_diff = ptr_diff(32'(wr_ptr), 32'(r_rd_ptr), ADDR_WIDTH + 1);

  always_ff @(posedge clk) begin
    if (rst) r_level <= '0;
    else     r_level <= w_diff[ADDR_WIDTH:0] + (ADDR_WIDTH+1)'(r_pend)
                        + (ADDR_WIDTH+1)'(w_buf_cnt);
  end

  assign level = r_level;
`endif

endmodule

// File: tb/tb_mfp_ram_read_streamer.sv
// Self-checking bench: directed vectors on a depth-64 instance plus a depth-4 wrap instance,
// with a stream scoreboard checked every cycle on the main instance.
module tb_mfp_ram_read_streamer;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int AW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] read_addr;
  logic          read_enable, out_valid, out_ready;
  logic [DW-1:0] read_data, out_data;

  logic [AW2:0]   wr_ptr_w, rd_ptr_w;
  logic [AW2-1:0] read_addr_w;
  logic           read_enable_w, out_valid_w, out_ready_w;
  logic [DW-1:0]  read_data_w, out_data_w;

`ifdef MFP_RAM_STREAMER_LEVEL_EN
  logic [AW:0]  level;
  logic [AW2:0] level_w;
`endif

  mfp_ram_read_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .read_addr(read_addr), .read_enable(read_enable), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MFP_RAM_STREAMER_LEVEL_EN
    , .level(level)
`endif
  );

  mfp_ram_read_streamer #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW)) u_dut_w (
    .clk(clk), .rst(rst), .wr_ptr(wr_ptr_w), .rd_ptr(rd_ptr_w),
    .read_addr(read_addr_w), .read_enable(read_enable_w), .read_data(read_data_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w)
`ifdef MFP_RAM_STREAMER_LEVEL_EN
    , .level(level_w)
`endif
  );

  // Registered-output RAMs with one cycle of read latency.
  logic [DW-1:0] mem   [64];
  logic [DW-1:0] mem_w [4];
  initial begin
    read_data   = '0;
    read_data_w = '0;
  end
  always @(posedge clk) if (read_enable)   read_data   <= mem[read_addr];
  always @(posedge clk) if (read_enable_w) read_data_w <= mem_w[read_addr_w];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Stream model: the k-th accepted word after reset must be RAM word k, held words
  // must not change, and at most two words may be read but not yet accepted.
  int            pop_cnt = 0;
  logic          hold_q  = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW:0]   outstanding;
  always @(negedge clk) begin
    if (rst) begin
      pop_cnt = 0;
      hold_q  = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(hold_data));
      end
      outstanding = rd_ptr - (AW+1)'(pop_cnt);
      chk("outstanding_le2", 64'(outstanding <= 2), 64'd1);
      if (read_enable) chk("issue_nonempty", 64'(wr_ptr != rd_ptr), 64'd1);
      if (out_valid && out_ready) begin
        chk("pop_data", 64'(out_data), 64'(mem[pop_cnt % 64]));
        pop_cnt++;
      end
      hold_q    = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int           k, written, t;
  logic         saw_wrap;
  logic [AW2:0] occ;

  initial begin
    rst = 1'b1; wr_ptr = '0; out_ready = 1'b0; wr_ptr_w = '0; out_ready_w = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem_w[i] = '0;
    #1;
    chk("rst_re_pre", 64'(read_enable), 64'd0);
    repeat (2) begin
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_rdptr", 64'(rd_ptr), 64'd0);
      chk("rst_re", 64'(read_enable), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
    end
    rst = 1'b0;
    tick();
    chk("idle_re", 64'(read_enable), 64'd0);

    // Latency: issue in N, out_valid in N+2.
    mem[0] = 32'hA5A5_0001;
    wr_ptr = 7'd1;
    #1;
    chk("lat_re", 64'(read_enable), 64'd1);
    chk("lat_addr", 64'(read_addr), 64'd0);
    tick();
    chk("lat_rdptr", 64'(rd_ptr), 64'd1);
    chk("lat_n1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'hA5A5_0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lat_drained", 64'(out_valid), 64'd0);

    // Streaming: 16 words, no bubbles after the first.
    for (int i = 0; i < 16; i++) mem[1+i] = DW'(i);
    wr_ptr = 7'd17;
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 6) begin tick(); t++; end
    chk("stream_first_delay", 64'(t), 64'd2);
    for (int i = 0; i < 16; i++) begin
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", 64'(out_data), 64'(i));
      tick();
    end
    chk("stream_end", 64'(out_valid), 64'd0);
    chk("stream_rdptr", 64'(rd_ptr), 64'd17);
    out_ready = 1'b0;

    // Backpressure: only two reads may issue while the consumer stalls.
    for (int i = 0; i < 8; i++) mem[17+i] = DW'(100 + i);
    wr_ptr = 7'd25;
    repeat (6) tick();
    chk("bp_rdptr", 64'(rd_ptr), 64'd19);
    chk("bp_re", 64'(read_enable), 64'd0);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_data", 64'(out_data), 64'd100);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_valid_drain", 64'(out_valid), 64'd1);
      chk("bp_data_drain", 64'(out_data), 64'(100 + i));
      tick();
    end
    chk("bp_end", 64'(out_valid), 64'd0);
    chk("bp_rdptr_end", 64'(rd_ptr), 64'd25);
    out_ready = 1'b0;

    // Mid-run reset with a word buffered and a read in flight.
    for (int i = 0; i < 4; i++) mem[25+i] = DW'(200 + i);
    wr_ptr = 7'd29;
    tick();
    tick();
    chk("mr_pre_rdptr", 64'(rd_ptr), 64'd27);
    chk("mr_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    wr_ptr = '0;
    tick();
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_rdptr", 64'(rd_ptr), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("mr_stale_valid", 64'(out_valid), 64'd0);
      chk("mr_stale_re", 64'(read_enable), 64'd0);
    end

    // Restart after reset.
    mem[0] = 32'h0000_0055;
    wr_ptr = 7'd1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("pr_valid", 64'(out_valid), 64'd1);
    chk("pr_data", 64'(out_data), 64'h55);
    tick();
    out_ready = 1'b0;

    // Wrap on a depth-4 instance: full FIFO is non-empty, pointer wraps, order preserved.
    for (int i = 0; i < 4; i++) mem_w[i] = DW'(300 + i);
    wr_ptr_w = 3'd4;
    #1;
    chk("full_re", 64'(read_enable_w), 64'd1);
    chk("full_addr", 64'(read_addr_w), 64'd0);
    out_ready_w = 1'b1;
    k = 0; written = 4; saw_wrap = 1'b0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      if (out_valid_w) begin
        chk("wrap_data", 64'(out_data_w), 64'(300 + k));
        k++;
      end
      occ = wr_ptr_w - rd_ptr_w;
      if (written < 10 && occ < 3'd4) begin
        mem_w[wr_ptr_w[1:0]] = DW'(300 + written);
        written++;
        wr_ptr_w = wr_ptr_w + 1'b1;
      end
      tick();
      if (rd_ptr_w == 3'd4 && read_addr_w == 2'd0) saw_wrap = 1'b1;
    end
    chk("wrap_count", 64'(k), 64'd10);
    chk("wrap_seen", 64'(saw_wrap), 64'd1);
    chk("wrap_rdptr", 64'(rd_ptr_w), 64'd2);
    chk("wrap_end", 64'(out_valid_w), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
